// File: rtl/noc_tx_flit_drain_if.sv
// ============================================================================
// Module  : noc_tx_flit_drain_if
// Brief   : FIFO-side, router-side and status signals of the flit drain stage.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface noc_tx_flit_drain_if #(
  parameter int CRED_W = 3
);
  logic              fifo_empty;
  logic [33:0]       fifo_data;
  logic              fifo_read_en;
  logic [33:0]       flit_out;
  logic              flit_valid;
  logic              credit_in;
  logic [CRED_W-1:0] credits;
  logic              err_framing;
  logic              err_credit;
  logic [15:0]       pkt_count;

  modport slave (
    input  fifo_empty, fifo_data, credit_in,
    output fifo_read_en, flit_out, flit_valid, credits,
           err_framing, err_credit, pkt_count
  );

  modport master (
    output fifo_empty, fifo_data, credit_in,
    input  fifo_read_en, flit_out, flit_valid, credits,
           err_framing, err_credit, pkt_count
  );
endinterface

`default_nettype wire

// File: rtl/noc_tx_flit_drain.sv
// ============================================================================
// Module  : noc_tx_flit_drain
// Brief   : Pops flits from a FWFT FIFO, checks framing and forwards them to
//           the router under credit flow control. Optional packet counter
//           built when NOC_TX_PKT_STATS_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_tx_flit_drain #(
  parameter int CREDITS = 4,
  parameter int CRED_W  = 3
) (
  input  logic                 clk,
  input  logic                 reset_n,
  noc_tx_flit_drain_if.slave   bus
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  localparam logic [1:0]        T_HEAD   = 2'b01;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

  state_t            state;
  logic [CRED_W-1:0] credit_cnt;
  logic [33:0]       flit_q;
  logic              valid_q;
  logic              err_framing_q;
  logic              err_credit_q;

  logic [1:0] ftype;
  logic       drop;
  logic       take;
  logic       send;

  // bit0 of the type marks a packet start (HEAD/SINGLE), bit1 a packet end (TAIL/SINGLE)
  assign ftype = bus.fifo_data[33:32];
  assign drop  = (state == IDLE) && !ftype[0];
  assign take  = !bus.fifo_empty && (drop || (credit_cnt != '0));
  assign send  = take && !drop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      credit_cnt    <= CRED_MAX;
      flit_q        <= '0;
      valid_q       <= 1'b0;
      err_framing_q <= 1'b0;
      err_credit_q  <= 1'b0;
    end else begin
      valid_q       <= send;
      err_credit_q  <= 1'b0;
      err_framing_q <= take && (drop || ((state == IN_PKT) && ftype[0]));

      if (send) begin
        flit_q <= bus.fifo_data;
        if (ftype == T_HEAD)
          state <= IN_PKT;
        else if (ftype[1])
          state <= IDLE;
      end

      case ({send, bus.credit_in})
        2'b10: credit_cnt <= credit_cnt - 1'b1;
        2'b01: begin
          if (credit_cnt == CRED_MAX)
            err_credit_q <= 1'b1;
          else
            credit_cnt <= credit_cnt + 1'b1;
        end
        default: credit_cnt <= credit_cnt;
      endcase
    end
  end

`ifdef NOC_TX_PKT_STATS_EN
  logic [15:0] pkt_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pkt_cnt_q <= '0;
    else if (send && ftype[1])
      pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign bus.pkt_count = pkt_cnt_q;
`else
  assign bus.pkt_count = '0;
`endif

  assign bus.fifo_read_en = take;
  assign bus.flit_out     = flit_q;
  assign bus.flit_valid   = valid_q;
  assign bus.credits      = credit_cnt;
  assign bus.err_framing  = err_framing_q;
  assign bus.err_credit   = err_credit_q;

endmodule

`default_nettype wire

// File: tb/tb_noc_tx_flit_drain.sv
// ============================================================================
// Module  : tb_noc_tx_flit_drain
// Brief   : Directed self-checking bench for noc_tx_flit_drain.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_tx_flit_drain;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

`ifdef NOC_TX_PKT_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  noc_tx_flit_drain_if #(.CRED_W(3)) bus ();

  noc_tx_flit_drain #(.CREDITS(4), .CRED_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // FWFT FIFO model: written by the stimulus, popped on read_en
  logic [33:0] mem [0:31];
  int wr = 0;
  int rd = 0;

  assign bus.fifo_empty = (rd == wr);
  assign bus.fifo_data  = mem[rd % 32];

  always @(posedge clk)
    if (bus.fifo_read_en && (rd != wr)) rd <= rd + 1;

  task automatic push(input logic [33:0] f);
    mem[wr % 32] = f;
    wr = wr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] pk(input int n);
    return STATS ? 16'(n) : 16'd0;
  endfunction

  initial begin
    bus.credit_in = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = '0;

    // ---- reset values
    tick(); tick();
    chk("rst_valid",   34'(bus.flit_valid),  34'd0);
    chk("rst_flit",    bus.flit_out,         34'd0);
    chk("rst_credits", 34'(bus.credits),     34'd4);
    chk("rst_errf",    34'(bus.err_framing), 34'd0);
    chk("rst_errc",    34'(bus.err_credit),  34'd0);
    chk("rst_pkt",     34'(bus.pkt_count),   34'd0);
    chk("rst_rden",    34'(bus.fifo_read_en),34'd0);
    reset_n = 1'b1;
    tick();

    // ---- 1: SINGLE
    push(34'h3_DEADBEEF);
    #1 chk("t1_rden", 34'(bus.fifo_read_en), 34'd1);
    tick();
    chk("t1_valid",   34'(bus.flit_valid), 34'd1);
    chk("t1_flit",    bus.flit_out,        34'h3_DEADBEEF);
    chk("t1_credits", 34'(bus.credits),    34'd3);
    chk("t1_pkt",     34'(bus.pkt_count),  34'(pk(1)));
    chk("t1_rden_empty", 34'(bus.fifo_read_en), 34'd0);
    tick();
    chk("t1_pulse",   34'(bus.flit_valid), 34'd0);
    chk("t1_hold",    bus.flit_out,        34'h3_DEADBEEF);
    bus.credit_in = 1'b1; tick(); bus.credit_in = 1'b0;
    chk("t1_ret", 34'(bus.credits), 34'd4);

    // ---- 2: full packet drains credits, next HEAD stalls
    push(34'h1_00000011); push(34'h0_00000022); push(34'h0_00000033);
    push(34'h2_00000044); push(34'h1_00000055);
    tick(); chk("t2_f0", bus.flit_out, 34'h1_00000011); chk("t2_c0", 34'(bus.credits), 34'd3);
    tick(); chk("t2_f1", bus.flit_out, 34'h0_00000022); chk("t2_v1", 34'(bus.flit_valid), 34'd1);
    tick(); chk("t2_f2", bus.flit_out, 34'h0_00000033); chk("t2_c2", 34'(bus.credits), 34'd1);
    tick(); chk("t2_f3", bus.flit_out, 34'h2_00000044); chk("t2_c3", 34'(bus.credits), 34'd0);
    chk("t2_pkt",   34'(bus.pkt_count),    34'(pk(2)));
    chk("t2_stall", 34'(bus.fifo_read_en), 34'd0);
    tick();
    chk("t2_nv",   34'(bus.flit_valid),   34'd0);
    chk("t2_hold", bus.flit_out,          34'h2_00000044);
    chk("t2_stall2", 34'(bus.fifo_read_en), 34'd0);

    // ---- 3: one credit releases the stalled HEAD
    bus.credit_in = 1'b1;
    #1 chk("t3_rden0", 34'(bus.fifo_read_en), 34'd0);
    tick(); bus.credit_in = 1'b0;
    chk("t3_c1",   34'(bus.credits),      34'd1);
    chk("t3_rden", 34'(bus.fifo_read_en), 34'd1);
    tick();
    chk("t3_v",    34'(bus.flit_valid), 34'd1);
    chk("t3_flit", bus.flit_out,        34'h1_00000055);
    chk("t3_c0",   34'(bus.credits),    34'd0);
    bus.credit_in = 1'b1; tick(); bus.credit_in = 1'b0;
    chk("t3_c1b", 34'(bus.credits), 34'd1);
    push(34'h0_00000066); bus.credit_in = 1'b1;
    tick(); bus.credit_in = 1'b0;
    chk("t3_sendcred_v", 34'(bus.flit_valid), 34'd1);
    chk("t3_sendcred_c", 34'(bus.credits),    34'd1);
    chk("t3_sendcred_e", 34'(bus.err_credit), 34'd0);
    push(34'h2_00000077);
    tick();
    chk("t3_tail", bus.flit_out, 34'h2_00000077);
    chk("t3_c",    34'(bus.credits), 34'd0);
    chk("t3_pkt",  34'(bus.pkt_count), 34'(pk(3)));
    bus.credit_in = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    bus.credit_in = 1'b0;
    chk("t3_refill", 34'(bus.credits), 34'd4);

    // ---- 4: BODY in IDLE is dropped
    push(34'h0_00000055);
    #1 chk("t4_rden", 34'(bus.fifo_read_en), 34'd1);
    tick();
    chk("t4_nv",   34'(bus.flit_valid),  34'd0);
    chk("t4_errf", 34'(bus.err_framing), 34'd1);
    chk("t4_c",    34'(bus.credits),     34'd4);
    chk("t4_hold", bus.flit_out,         34'h2_00000077);
    chk("t4_empty", 34'(bus.fifo_empty), 34'd1);
    push(34'h3_00000088);
    tick();
    chk("t4_idle_v",  34'(bus.flit_valid),  34'd1);
    chk("t4_idle_e",  34'(bus.err_framing), 34'd0);
    chk("t4_pkt",     34'(bus.pkt_count),   34'(pk(4)));
    bus.credit_in = 1'b1; tick(); bus.credit_in = 1'b0;

    // ---- 5: HEAD inside a packet, then credit overflow
    push(34'h1_000000A1); push(34'h1_000000A2);
    tick(); chk("t5_h1e", 34'(bus.err_framing), 34'd0); chk("t5_h1c", 34'(bus.credits), 34'd3);
    tick();
    chk("t5_h2v",  34'(bus.flit_valid),  34'd1);
    chk("t5_h2f",  bus.flit_out,         34'h1_000000A2);
    chk("t5_h2e",  34'(bus.err_framing), 34'd1);
    push(34'h2_000000A3);
    tick();
    chk("t5_tv",  34'(bus.flit_valid),  34'd1);
    chk("t5_te",  34'(bus.err_framing), 34'd0);
    chk("t5_pkt", 34'(bus.pkt_count),   34'(pk(5)));
    bus.credit_in = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    chk("t5_full", 34'(bus.credits), 34'd4);
    chk("t5_noerr", 34'(bus.err_credit), 34'd0);
    tick(); bus.credit_in = 1'b0;
    chk("t5_errc", 34'(bus.err_credit), 34'd1);
    chk("t5_sat",  34'(bus.credits),    34'd4);
    tick();
    chk("t5_errc_clr", 34'(bus.err_credit), 34'd0);

    // ---- 6: async reset mid-packet
    push(34'h1_000000B1); push(34'h0_000000B2);
    tick(); tick();
    chk("t6_pre_v", 34'(bus.flit_valid), 34'd1);
    chk("t6_pre_c", 34'(bus.credits),    34'd2);
    reset_n = 1'b0;
    #1;
    chk("t6_async_v", 34'(bus.flit_valid), 34'd0);
    chk("t6_async_c", 34'(bus.credits),    34'd4);
    chk("t6_async_f", bus.flit_out,        34'd0);
    chk("t6_async_p", 34'(bus.pkt_count),  34'd0);
    tick();
    reset_n = 1'b1;
    push(34'h0_000000B3);
    #1 chk("t6_rden", 34'(bus.fifo_read_en), 34'd1);
    tick();
    chk("t6_drop_v", 34'(bus.flit_valid),  34'd0);
    chk("t6_drop_e", 34'(bus.err_framing), 34'd1);
    chk("t6_drop_c", 34'(bus.credits),     34'd4);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
